// File: rtl/riscv_pkg.sv
// Shared RISC-V core types.
// Word sizes and the fetch-to-decode bundle.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int ILEN       = 32;
  localparam int INST_BYTES = 4;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [ILEN-1:0] inst_t;

  typedef struct packed {
    addr_t pc;
    inst_t inst;
  } if_id_t;

  function automatic addr_t align_pc(
    input addr_t pc
  );
    return pc & ~addr_t'(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: memory request/response,
// redirect from execute, and instruction hand-off to decode.
interface instruction_fetch_if;
  import riscv_pkg::*;

  logic  mem_req_valid;
  logic  mem_req_ready;
  addr_t mem_req_addr;
  logic  mem_rsp_valid;
  inst_t mem_rsp_data;
  logic  redirect_valid;
  addr_t redirect_pc;
  logic  inst_valid;
  logic  inst_ready;
  inst_t inst_data;
  addr_t inst_pc;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    input  inst_ready
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    output inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush.
// Head reads as zero while empty so idle outputs stay clean.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: credit-limited PC requests,
// in-order response buffering, redirect flush with drop count.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter addr_t RESET_PC   = 32'h0000_0000,
  parameter int    FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  instruction_fetch_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  addr_t         fetch_pc;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] outstanding;
  logic [CW:0]   credit_used;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pcq_full;
  logic          pcq_empty;
  logic          req_fire;
  logic          rsp_pop;
  logic          rsp_keep;
  logic          inst_pop;
  addr_t         rsp_pc;
  if_id_t        rsp_entry;
  if_id_t        head;

  // Buffered plus in-flight entries can never exceed the buffer size.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};

  assign bus.mem_req_valid = reset_n
                          && !bus.redirect_valid
                          && !pcq_full
                          && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign bus.mem_req_addr  = fetch_pc;

  assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
  assign rsp_pop  = bus.mem_rsp_valid && !pcq_empty;
  assign rsp_keep = rsp_pop
                 && !bus.redirect_valid
                 && (drop_cnt == '0)
                 && !fifo_full;
  assign inst_pop = !fifo_empty
                 && bus.inst_ready
                 && !bus.redirect_valid;

  assign rsp_entry = '{pc: rsp_pc, inst: bus.mem_rsp_data};

  assign bus.inst_valid = !fifo_empty;
  assign bus.inst_data  = head.inst;
  assign bus.inst_pc    = head.pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= align_pc(bus.redirect_pc);
      drop_cnt <= drop_cnt + outstanding
                - CW'(bus.mem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + addr_t'(INST_BYTES);
      end
      if (rsp_pop && drop_cnt != '0) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(if_id_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rsp_keep),
    .push_data (rsp_entry),
    .pop       (inst_pop),
    .flush     (bus.redirect_valid),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // In-flight PCs survive a redirect; their responses still pop them.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_pop),
    .flush     (1'b0),
    .pop_data  (rsp_pc),
    .full      (pcq_full),
    .empty     (pcq_empty),
    .count     (outstanding)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a latency-configurable
// memory model and an expected-delivery scoreboard.
module tb_instruction_fetch;
  import riscv_pkg::*;

  typedef struct {
    addr_t addr;
    int    due;
  } pend_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   mem_lat = 1;
  int   acc = 0;
  int   a0;
  int   cyc = 0;
  pend_t  pq[$];
  pend_t  p;
  if_id_t exp_q[$];

  always #5 clk = ~clk;

  instruction_fetch_if bus();

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic inst_t rom(input addr_t a);
    if (a == 32'h0) return 32'h0020_0293;
    if (a == 32'h4) return 32'h0012_d313;
    return 32'hC0DE_0000 ^ a;
  endfunction

  // In-order memory: response presented mem_lat cycles after accept.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pq.delete();
      bus.mem_rsp_valid <= 1'b0;
      bus.mem_rsp_data  <= '0;
    end else begin
      if (bus.mem_req_valid && bus.mem_req_ready)
        pq.push_back('{addr: bus.mem_req_addr, due: cyc + mem_lat - 1});
      if (pq.size() > 0 && pq[0].due <= cyc) begin
        p = pq.pop_front();
        bus.mem_rsp_valid <= 1'b1;
        bus.mem_rsp_data  <= rom(p.addr);
      end else begin
        bus.mem_rsp_valid <= 1'b0;
      end
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    chk(tag, {31'd0, got}, {31'd0, exp});
  endtask

  task automatic push_exp(input addr_t pc, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{pc: pc + addr_t'(4*i), inst: rom(pc + addr_t'(4*i))});
  endtask

  // Sample just after inputs settle; handshakes complete at next posedge.
  task automatic look();
    if_id_t e;
    #1;
    if (bus.mem_req_valid && bus.mem_req_ready) acc++;
    if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_unexpected: got pc %h expected no delivery",
                 bus.inst_pc);
        end
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", bus.inst_pc, e.pc);
        chk("sb_data", bus.inst_data, e.inst);
      end
    end
  endtask

  task automatic drive(input int rq, input int ir, input int rv,
                       input addr_t rp);
    bus.mem_req_ready  = (rq != 0);
    bus.inst_ready     = (ir != 0);
    bus.redirect_valid = (rv != 0);
    bus.redirect_pc    = rp;
    look();
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input int rq, input int ir);
    repeat (n) begin
      drive(rq, ir, 0, 32'h0);
      tick();
    end
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, "_req_valid"}, bus.mem_req_valid, 1'b0);
    chk({tag, "_req_addr"}, bus.mem_req_addr, 32'h0);
    chk1({tag, "_inst_valid"}, bus.inst_valid, 1'b0);
    chk({tag, "_inst_data"}, bus.inst_data, 32'h0);
    chk({tag, "_inst_pc"}, bus.inst_pc, 32'h0);
  endtask

  initial begin
    bus.mem_req_ready  = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (3) tick();

    // Reset values
    drive(0, 0, 0, 32'h0);
    chk_reset("rst");
    tick();

    // Free run, 1-cycle memory
    reset_n = 1'b1;
    push_exp(32'h0, 3);
    drive(1, 1, 0, 32'h0);
    chk1("t1_req_valid", bus.mem_req_valid, 1'b1);
    chk("t1_req_addr", bus.mem_req_addr, 32'h0);
    tick();
    drive(1, 1, 0, 32'h0);
    chk1("t1_lat1", bus.inst_valid, 1'b0);
    tick();
    drive(1, 1, 0, 32'h0);
    chk1("t1_lat2", bus.inst_valid, 1'b1);
    chk("t1_pc0", bus.inst_pc, 32'h0);
    tick();
    drive(0, 1, 0, 32'h0);
    chk("t1_pc4", bus.inst_pc, 32'h4);
    tick();
    idle(3, 0, 1);
    chk("t1_drain", 32'(exp_q.size()), 32'd0);
    chk1("t1_idle", bus.inst_valid, 1'b0);

    // Back-pressure: credit caps requests at FIFO_DEPTH
    drive(0, 0, 1, 32'h0);
    chk1("t2_redir_noreq", bus.mem_req_valid, 1'b0);
    tick();
    a0 = acc;
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, 0, 32'h0);
      if (k >= 2) begin
        chk1("t2_hold_valid", bus.inst_valid, 1'b1);
        chk("t2_hold_pc", bus.inst_pc, 32'h0);
      end
      tick();
    end
    chk("t2_issued", 32'(acc - a0), 32'd4);
    push_exp(32'h0, 4);
    drive(0, 1, 0, 32'h0);
    chk1("t2_capped", bus.mem_req_valid, 1'b0);
    tick();
    drive(0, 1, 0, 32'h0);
    chk1("t2_next_valid", bus.mem_req_valid, 1'b1);
    chk("t2_next_addr", bus.mem_req_addr, 32'h10);
    tick();
    idle(4, 0, 1);
    chk("t2_drain", 32'(exp_q.size()), 32'd0);

    // Redirect with two requests in flight
    mem_lat = 3;
    drive(1, 1, 0, 32'h0);
    tick();
    drive(1, 1, 0, 32'h0);
    tick();
    drive(0, 1, 1, 32'h103);
    chk1("t3_redir_noreq", bus.mem_req_valid, 1'b0);
    tick();
    mem_lat = 1;
    push_exp(32'h100, 1);
    drive(1, 1, 0, 32'h0);
    chk1("t3_req_valid", bus.mem_req_valid, 1'b1);
    chk("t3_req_addr", bus.mem_req_addr, 32'h100);
    tick();
    idle(6, 0, 1);
    chk("t3_drain", 32'(exp_q.size()), 32'd0);

    // Withdrawn request while memory stalls
    reset_n = 1'b0;
    drive(0, 0, 0, 32'h0);
    tick();
    reset_n = 1'b1;
    drive(0, 0, 0, 32'h0);
    chk1("t4_req_valid", bus.mem_req_valid, 1'b1);
    chk("t4_req_addr0", bus.mem_req_addr, 32'h0);
    tick();
    drive(0, 0, 1, 32'h40);
    chk1("t4_withdraw", bus.mem_req_valid, 1'b0);
    tick();
    drive(0, 0, 0, 32'h0);
    chk1("t4_new_valid", bus.mem_req_valid, 1'b1);
    chk("t4_new_addr", bus.mem_req_addr, 32'h40);
    tick();
    push_exp(32'h40, 1);
    drive(1, 1, 0, 32'h0);
    tick();
    idle(4, 0, 1);
    chk("t4_drain", 32'(exp_q.size()), 32'd0);

    // Redirect coincident with response and decode ready
    drive(1, 0, 0, 32'h0);
    tick();
    drive(1, 0, 0, 32'h0);
    tick();
    drive(0, 1, 1, 32'h200);
    chk1("t5_pre_valid", bus.inst_valid, 1'b1);
    chk("t5_pre_pc", bus.inst_pc, 32'h44);
    tick();
    drive(0, 1, 0, 32'h0);
    chk1("t5_flushed", bus.inst_valid, 1'b0);
    tick();
    idle(3, 0, 1);
    chk1("t5_no_stale", bus.inst_valid, 1'b0);
    push_exp(32'h200, 1);
    drive(1, 1, 0, 32'h0);
    tick();
    idle(4, 0, 1);
    chk("t5_drain", 32'(exp_q.size()), 32'd0);

    // Async reset with three buffered entries
    repeat (3) begin
      drive(1, 0, 0, 32'h0);
      tick();
    end
    drive(0, 0, 0, 32'h0);
    tick();
    drive(0, 0, 0, 32'h0);
    chk1("t6_full_valid", bus.inst_valid, 1'b1);
    chk("t6_head_pc", bus.inst_pc, 32'h204);
    #2 reset_n = 1'b0;
    #1;
    chk_reset("t6_rst");
    tick();
    drive(0, 0, 0, 32'h0);
    tick();
    reset_n = 1'b1;
    push_exp(32'h0, 1);
    drive(1, 1, 0, 32'h0);
    chk1("t6_refetch_valid", bus.mem_req_valid, 1'b1);
    chk("t6_refetch_addr", bus.mem_req_addr, 32'h0);
    tick();
    idle(4, 0, 1);
    chk("t6_drain", 32'(exp_q.size()), 32'd0);
    chk1("t6_idle", bus.inst_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage between the program ROM (loaded from `ROMFILE`) and the CPU decode stage inside `soc`. It holds the PC and issues word-aligned read requests over a valid/ready bus. It buffers returned instructions with their PCs in a small FIFO and hands them to decode over a valid/ready handshake. On a redirect (branch/jump resolved downstream) it flushes all buffered and in-flight fetches and restarts at the new PC.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset
- `FIFO_DEPTH`, 4, instruction buffer entries; power of two, ≥2; also the cap on outstanding requests

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1 — clock, all state on rising edge
- `reset_n` in 1 — asynchronous active-low reset
- `mem_req_valid` out 1 — read request valid
- `mem_req_ready` in 1 — memory accepts request
- `mem_req_addr` out 32 — byte address, bits [1:0] always 0
- `mem_rsp_valid` in 1 — read data valid; one per accepted request, in order, ≥1 cycle after acceptance
- `mem_rsp_data` in 32 — instruction word
- `redirect_valid` in 1 — flush and restart fetch
- `redirect_pc` in 32 — new PC; bits [1:0] ignored (treated as 0)
- `inst_valid` out 1 — `inst_data`/`inst_pc` valid to decode
- `inst_ready` in 1 — decode consumes the entry
- `inst_data` out 32 — instruction word
- `inst_pc` out 32 — address it was fetched from

## Operation
- Registers: `fetch_pc` (next request address), `outstanding` (accepted, not yet returned), `drop_cnt` (returns to discard), FIFO of {pc, inst}, queue of PCs for in-flight requests.
- Issue: `mem_req_valid = !redirect_valid && (fifo_count + outstanding < FIFO_DEPTH)`; `mem_req_addr = fetch_pc`. On accept: `fetch_pc += 4` (wraps mod 2^32), `outstanding++`, push address to in-flight PC queue.
- Return: on `mem_rsp_valid`, pop in-flight PC. If `drop_cnt > 0`, discard and `drop_cnt--`. Otherwise push {pc, data} to FIFO. `outstanding--` in both cases.
- Deliver: `inst_valid = fifo not empty`; pop on `inst_valid && inst_ready`. No response-to-output bypass.
- Redirect (highest priority): FIFO emptied; `fetch_pc <= {redirect_pc[31:2],2'b00}`.
  - `drop_cnt <= outstanding + drop_cnt − (mem_rsp_valid ? 1 : 0)`. Any response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle. An unaccepted pending request is withdrawn, which this bus permits. A decode pop in the same cycle is ignored.
- Simultaneous push and pop on the FIFO: both occur, count unchanged. Full FIFO cannot be overrun because the credit rule is enforced at issue.
- No exceptions raised here; misalignment is resolved upstream.

## Timing
- Reset (async assert): `mem_req_valid` 0, `mem_req_addr` = RESET_PC, `inst_valid` 0, `inst_data` 0, `inst_pc` 0. FIFO and PC queue empty, `outstanding` 0, `drop_cnt` 0, `fetch_pc` = RESET_PC. Memory is reset by the same `reset_n`, so nothing is in flight after reset.
- First cycle after deassert: `mem_req_valid`=1, addr RESET_PC.
- Latency: request accepted at edge N, response in cycle N+1 → `inst_valid` in cycle N+2 (2 cycles request-to-decode at 1-cycle memory).
- Throughput: 1 instr/cycle sustained with `FIFO_DEPTH`≥3, 1-cycle memory, `inst_ready`=1.
- Redirect in cycle R: `inst_valid`=0 in R+1; first request to new PC in R+1; its instruction is valid in R+3 at earliest.
- `inst_*` held stable while `inst_valid && !inst_ready`.

## Structure
- Shared package `riscv_pkg`: `XLEN`=32, `ILEN`=32, `INST_BYTES`=4. `RESET_PC` default comes from the SoC parameter.
- Sub-module `fetch_fifo`: synchronous FIFO (parameter WIDTH, DEPTH; push, pop, flush, full, empty, count), instantiated for {pc, inst} (64 bits). A second instance of DEPTH `FIFO_DEPTH` holds in-flight PCs.
- `soc` instantiates `instruction_fetch` inside `cpu_inst`, ahead of decode.

## Test plan
- Reset then free-run, 1-cycle memory, ROM words 0x00200293 (addi x5,x0,2) and 0x0012d313 (srli x6,x5,1) at 0x0/0x4 → `inst_pc` 0x0 then 0x4 on consecutive cycles, first `inst_valid` 2 cycles after first accept.
- `inst_ready`=0 for 10 cycles → exactly 4 requests issued, `inst_valid` held with pc 0x0 stable; release → pcs 0x0,0x4,0x8,0xC delivered in order, next request 0x10.
- Redirect to 0x103 with 2 requests outstanding → both responses dropped; next request addr 0x100; first delivered `inst_pc`=0x100.
- `mem_req_ready` low 3 cycles, redirect in cycle 2 to 0x40 → withdrawn 0x0 request never returns; next request addr 0x40.
- Redirect coincident with `mem_rsp_valid` and `inst_ready` → that response discarded, FIFO empty next cycle, no stale pc reaches decode.
- Assert `reset_n` low mid-stream with FIFO holding 3 entries → all outputs at reset values immediately; after release, refetch starts at RESET_PC.
